// File: rtl/axi_burst_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst writer and the interconnect.
interface axi_burst_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;
    logic                    m_awvalid;
    logic                    m_awready;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;
    logic [1:0]              m_bresp;
    logic                    m_bvalid;
    logic                    m_bready;

    modport master (
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axi_burst_writer.sv
// Drains req_len words from a show-ahead line FIFO onto an AXI4 write channel as INCR bursts
// bounded by MAX_BURST and 4KB, one burst outstanding at a time, advancing a frame address pointer.
// Optional build macro AXI_WR_ERR_CNT_EN adds err_flag_o / err_cnt_o error-response tracking.
//
// state | meaning
// IDLE  | waiting for burst_req / tail_req; frame_sync reloads the address pointer
// ADDR  | computing the next chunk, then presenting AW until accepted
// DATA  | streaming FIFO words until the wlast beat is accepted
// BRSP  | waiting for the write response of the current burst
// DONE  | one-cycle done pulse; pending frame_sync applied on the way back to IDLE
module axi_burst_writer #(
    parameter int LSIZE      = 9,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 256
) (
    input  logic                  clock_i,
    input  logic                  rst_i,
    input  logic                  burst_req_i,
    input  logic                  tail_req_i,
    input  logic [LSIZE-1:0]      req_len_i,
    output logic                  resp_o,
    output logic                  done_o,
    input  logic                  frame_sync_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    axi_burst_writer_if.master    axi
`ifdef AXI_WR_ERR_CNT_EN
    ,
    output logic                  err_flag_o,
    output logic [15:0]           err_cnt_o
`endif
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int AWSIZE = $clog2(BYTES);
    // Chunk arithmetic must hold both a full request length and a 4KB page worth of byte-wide beats.
    localparam int CW     = (LSIZE > 13) ? LSIZE : 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BRSP,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [LSIZE-1:0]        remain_q;
    logic [ADDR_WIDTH-1:0]   addr_ptr_q;
    logic                    sync_pend_q;
    logic [8:0]              chunk_q;
    logic [8:0]              beat_q;
    logic                    resp_q;
    logic                    done_q;
    logic                    awvalid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [7:0]              awlen_q;
    logic                    bready_q;

    logic [12:0]             room_bytes;
    logic [CW-1:0]           room_beats;
    logic [CW-1:0]           chunk_full;
    logic [8:0]              chunk_d;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic                    wvalid;
    logic                    wlast;
    logic                    w_fire;

    // Next burst length: smallest of what is left, the burst cap and the beats left in this 4KB page.
    always_comb begin
        room_bytes = 13'd4096 - {1'b0, addr_ptr_q[11:0]};
        room_beats = CW'(room_bytes >> AWSIZE);
        chunk_full = CW'(remain_q);
        if (CW'(MAX_BURST) < chunk_full) begin
            chunk_full = CW'(MAX_BURST);
        end
        if (room_beats < chunk_full) begin
            chunk_full = room_beats;
        end
        chunk_d = chunk_full[8:0];
    end

    assign addr_inc = ADDR_WIDTH'(chunk_q) << AWSIZE;

    // W is only offered in DATA, so no beat can precede its AW handshake; FWFT head is the data.
    assign wvalid = (state_q == S_DATA) && !fifo_empty_i;
    assign wlast  = (state_q == S_DATA) && (beat_q == 9'(chunk_q - 9'd1));
    assign w_fire = wvalid && axi.m_wready;

    assign axi.m_awaddr  = awaddr_q;
    assign axi.m_awlen   = awlen_q;
    assign axi.m_awsize  = 3'(AWSIZE);
    assign axi.m_awburst = 2'b01;
    assign axi.m_awvalid = awvalid_q;
    assign axi.m_wdata   = fifo_dout_i;
    assign axi.m_wstrb   = '1;
    assign axi.m_wlast   = wlast;
    assign axi.m_wvalid  = wvalid;
    assign axi.m_bready  = bready_q;
    assign fifo_rd_en_o  = w_fire;
    assign resp_o        = resp_q;
    assign done_o        = done_q;

    // Request sequencing, burst splitting and address pointer maintenance.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            remain_q    <= '0;
            addr_ptr_q  <= '0;
            sync_pend_q <= 1'b0;
            chunk_q     <= '0;
            beat_q      <= '0;
            resp_q      <= 1'b0;
            done_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            bready_q    <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            done_q <= 1'b0;
            // A frame_sync during a request is deferred so the request finishes at its old addresses.
            if (frame_sync_i && (state_q != S_IDLE)) begin
                sync_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (frame_sync_i) begin
                        addr_ptr_q <= base_addr_i;
                    end
                    // Both request flavours carry their length on req_len; tail simply has priority.
                    if (tail_req_i || burst_req_i) begin
                        remain_q <= req_len_i;
                        resp_q   <= 1'b1;
                        if (req_len_i == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (!awvalid_q) begin
                        awvalid_q <= 1'b1;
                        awaddr_q  <= addr_ptr_q;
                        awlen_q   <= 8'(chunk_d - 9'd1);
                        chunk_q   <= chunk_d;
                    end else if (axi.m_awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        if (wlast) begin
                            bready_q <= 1'b1;
                            state_q  <= S_BRSP;
                        end else begin
                            beat_q <= beat_q + 9'd1;
                        end
                    end
                end
                S_BRSP: begin
                    if (axi.m_bvalid) begin
                        bready_q   <= 1'b0;
                        remain_q   <= remain_q - LSIZE'(chunk_q);
                        addr_ptr_q <= addr_ptr_q + addr_inc;
                        if (remain_q == LSIZE'(chunk_q)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    if (sync_pend_q || frame_sync_i) begin
                        addr_ptr_q  <= base_addr_i;
                        sync_pend_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_WR_ERR_CNT_EN
    logic        err_flag_q;
    logic [15:0] err_cnt_q;
    logic        b_err;

    assign b_err      = axi.m_bvalid && bready_q && axi.m_bresp[1];
    assign err_flag_o = err_flag_q;
    assign err_cnt_o  = err_cnt_q;

    // Sticky per-frame error flag and saturating lifetime count of SLVERR/DECERR responses.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (b_err) begin
                err_flag_q <= 1'b1;
            end else if (frame_sync_i) begin
                err_flag_q <= 1'b0;
            end
            if (b_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end
`else
    // Without error tracking the response code does not influence flow.
    logic unused_bresp;
    assign unused_bresp = ^axi.m_bresp;
`endif
endmodule

// File: tb/tb_axi_burst_writer.sv
// Scoreboard bench for axi_burst_writer: expected AW/W/event streams are queued as stimulus is
// issued and a monitor pops and compares them whenever the DUT presents a handshake or pulse.
module tb_axi_burst_writer;
    localparam int LSIZE  = 9;
    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int BUDGET = 4000;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } w_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             burst_req = 1'b0;
    logic             tail_req = 1'b0;
    logic [LSIZE-1:0] req_len = '0;
    logic             frame_sync = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [DW-1:0]    fifo_dout = '0;
    logic             fifo_empty = 1'b1;
    logic             resp;
    logic             done;
    logic             fifo_rd_en;
`ifdef AXI_WR_ERR_CNT_EN
    logic             err_flag;
    logic [15:0]      err_cnt;
`endif

    axi_burst_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_burst_writer #(
        .LSIZE(LSIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(256)
    ) dut (
        .clock_i(clk),
        .rst_i(rst),
        .burst_req_i(burst_req),
        .tail_req_i(tail_req),
        .req_len_i(req_len),
        .resp_o(resp),
        .done_o(done),
        .frame_sync_i(frame_sync),
        .base_addr_i(base_addr),
        .fifo_dout_i(fifo_dout),
        .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(fifo_rd_en),
        .axi(axi)
`ifdef AXI_WR_ERR_CNT_EN
        ,
        .err_flag_o(err_flag),
        .err_cnt_o(err_cnt)
`endif
    );

    aw_t           exp_aw[$];
    w_t            exp_w[$];
    int            exp_ev[$];
    logic [DW-1:0] fifo_q[$];

    int            total = 0;
    int            bad = 0;
    int            rd_cnt = 0;
    int            w_cnt = 0;
    int            rd0 = 0;
    bit            aw_out = 1'b0;
    bit            rand_en = 1'b0;
    bit            err_resp = 1'b0;
    bit            done_early = 1'b0;
    logic [31:0]   seq = 32'd0;

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string msg);
        total++;
        bad++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Queue one expected burst and load its words into the FIFO model.
    task automatic push_burst(input logic [AW-1:0] addr, input int beats);
        aw_t a;
        w_t  w;
        a.addr = addr;
        a.len  = 8'(beats - 1);
        exp_aw.push_back(a);
        for (int i = 0; i < beats; i++) begin
            w.data = {32'hC0DE0000 + seq, seq};
            w.last = (i == beats - 1);
            fifo_q.push_back(w.data);
            exp_w.push_back(w);
            seq++;
        end
    endtask

    task automatic start_req(input bit tail, input bit burst, input int len,
                             input bit fsync, input logic [AW-1:0] base);
        bit got;
        exp_ev.push_back(1);
        exp_ev.push_back(2);
        rd0 = rd_cnt;
        done_early = 1'b0;
        @(negedge clk);
        tail_req  = tail;
        burst_req = burst;
        req_len   = LSIZE'(len);
        if (fsync) begin
            frame_sync = 1'b1;
            base_addr  = base;
        end
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
        got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (resp) begin
                got = 1'b1;
                done_early = done;
                break;
            end
        end
        tail_req  = 1'b0;
        burst_req = 1'b0;
        if (!got) note_fail("resp_timeout", "no resp pulse within budget");
    endtask

    task automatic finish_req(input int len);
        bit got;
        got = done_early;
        for (int i = 0; i < BUDGET && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) note_fail("done_timeout", "no done pulse within budget");
        repeat (4) @(negedge clk);
        chk("rd_en_count", 64'(rd_cnt - rd0), 64'(len));
        chk("aw_left", 64'(exp_aw.size()), 64'd0);
        chk("w_left", 64'(exp_w.size()), 64'd0);
        chk("events_left", 64'(exp_ev.size()), 64'd0);
    endtask

    // AXI slave and FIFO model: readies, B responses and pops decided after each edge.
    initial begin : slave
        bit aw_hs;
        bit wl_hs;
        bit b_hs;
        bit rd;
        bit r;
        bit stall;
        int bpend;
        bpend = 0;
        axi.m_awready = 1'b0;
        axi.m_wready  = 1'b0;
        axi.m_bvalid  = 1'b0;
        axi.m_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            aw_hs = axi.m_awvalid && axi.m_awready;
            wl_hs = axi.m_wvalid && axi.m_wready && axi.m_wlast;
            b_hs  = axi.m_bvalid && axi.m_bready;
            rd    = fifo_rd_en;
            r     = rst;
            @(posedge clk);
            #1;
            if (r) begin
                fifo_q.delete();
                bpend = 0;
                axi.m_bvalid = 1'b0;
            end else begin
                if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (wl_hs) bpend++;
                if (b_hs) axi.m_bvalid = 1'b0;
                if (!axi.m_bvalid && bpend > 0 && (!rand_en || $urandom_range(0, 2) == 0)) begin
                    axi.m_bvalid = 1'b1;
                    axi.m_bresp  = err_resp ? 2'b10 : 2'b00;
                    bpend--;
                end
            end
            if (aw_hs) axi.m_awready = 1'b0;
            axi.m_awready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.m_wready  = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            stall         = rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            fifo_empty    = (fifo_q.size() == 0) || stall;
            fifo_dout     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor: pops the scoreboard on every handshake or pulse the DUT presents.
    initial begin : monitor
        aw_t a;
        w_t  w;
        int  ev;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_aw.delete();
                exp_w.delete();
                exp_ev.delete();
                aw_out = 1'b0;
            end else begin
                if (axi.m_wvalid || fifo_rd_en) begin
                    chk("rd_en_vs_handshake", fifo_rd_en, axi.m_wvalid & axi.m_wready);
                    chk("wvalid_while_empty", axi.m_wvalid & fifo_empty, 1'b0);
                end
                if (fifo_rd_en) rd_cnt++;
                if (axi.m_wvalid && axi.m_wready) begin
                    chk("w_after_aw", aw_out, 1'b1);
                    if (exp_w.size() == 0) begin
                        note_fail("w_extra_beat", $sformatf("unexpected beat data 0x%0h", axi.m_wdata));
                    end else begin
                        w = exp_w.pop_front();
                        chk("wdata", axi.m_wdata, w.data);
                        chk("wlast", axi.m_wlast, w.last);
                    end
                    w_cnt++;
                    if (axi.m_wlast) aw_out = 1'b0;
                end
                if (axi.m_awvalid && axi.m_awready) begin
                    if (exp_aw.size() == 0) begin
                        note_fail("aw_extra", $sformatf("unexpected AW addr 0x%0h len %0d", axi.m_awaddr, axi.m_awlen));
                    end else begin
                        a = exp_aw.pop_front();
                        chk("awaddr", axi.m_awaddr, a.addr);
                        chk("awlen", axi.m_awlen, a.len);
                    end
                    chk("awsize", axi.m_awsize, 3'd3);
                    chk("awburst", axi.m_awburst, 2'b01);
                    aw_out = 1'b1;
                end
                if (resp) begin
                    if (exp_ev.size() == 0) begin
                        note_fail("resp_extra", "resp pulse with nothing expected");
                    end else begin
                        ev = exp_ev.pop_front();
                        chk("resp_order", 64'(ev), 64'd1);
                    end
                end
                if (done) begin
                    if (exp_ev.size() == 0) begin
                        note_fail("done_extra", "done pulse with nothing expected");
                    end else begin
                        ev = exp_ev.pop_front();
                        chk("done_order", 64'(ev), 64'd2);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  w0;
        bit  got;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp", resp, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_awvalid", axi.m_awvalid, 1'b0);
        chk("rst_wvalid", axi.m_wvalid, 1'b0);
        chk("rst_wlast", axi.m_wlast, 1'b0);
        chk("rst_bready", axi.m_bready, 1'b0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("wstrb", axi.m_wstrb, 8'hFF);

        // Single burst at a new base, FIFO pre-filled, no stalls.
        push_burst(32'h0000_1000, 200);
        start_req(1'b0, 1'b1, 200, 1'b1, 32'h0000_1000);
        finish_req(200);

        // MAX_BURST split: 256 + 44 beats.
        push_burst(32'h0000_0000, 256);
        push_burst(32'h0000_0800, 44);
        start_req(1'b0, 1'b1, 300, 1'b1, 32'h0000_0000);
        finish_req(300);

        // Random stalls from here on; 4KB split at 0xFC0.
        rand_en = 1'b1;
        push_burst(32'h0000_0FC0, 8);
        push_burst(32'h0000_1000, 8);
        start_req(1'b0, 1'b1, 16, 1'b1, 32'h0000_0FC0);
        finish_req(16);

        // Zero-length tail: resp and done, no AXI traffic.
        start_req(1'b1, 1'b0, 0, 1'b0, '0);
        finish_req(0);

        // Tail and burst together with an error response that must not disturb flow.
        err_resp = 1'b1;
        push_burst(32'h0000_1040, 5);
        start_req(1'b1, 1'b1, 5, 1'b0, '0);
        finish_req(5);
        err_resp = 1'b0;

        // frame_sync mid-request: current burst stays at old address, next starts at base.
        push_burst(32'h0000_1068, 20);
        start_req(1'b0, 1'b1, 20, 1'b0, '0);
        @(negedge clk);
        frame_sync = 1'b1;
        base_addr  = 32'h0000_4000;
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
        finish_req(20);
        push_burst(32'h0000_4000, 3);
        start_req(1'b0, 1'b1, 3, 1'b0, '0);
        finish_req(3);

        // Reset in the middle of the data phase.
        push_burst(32'h0000_4018, 50);
        start_req(1'b0, 1'b1, 50, 1'b0, '0);
        w0 = w_cnt;
        got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (w_cnt >= w0 + 5) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) note_fail("mid_data_timeout", "data phase never progressed");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_awvalid", axi.m_awvalid, 1'b0);
        chk("midrst_wvalid", axi.m_wvalid, 1'b0);
        chk("midrst_wlast", axi.m_wlast, 1'b0);
        chk("midrst_bready", axi.m_bready, 1'b0);
        chk("midrst_rd_en", fifo_rd_en, 1'b0);
        chk("midrst_done", done, 1'b0);

        // Address pointer restarts at zero after reset.
        push_burst(32'h0000_0000, 4);
        start_req(1'b0, 1'b1, 4, 1'b0, '0);
        finish_req(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
